// File: rtl/uart_rx.sv
// Console UART receiver: 8N1, LSB first, 16x oversampled on the shared mclkx16 enable.
// Holds one byte with ready, framing-error and overrun flags for the CPU side.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mclkx16,
    input  logic       rx,
    input  logic       rx_read,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   rxs;
    logic [3:0]             cnt;
    logic [2:0]             bitn;
    logic [7:0]             shift;
    logic                   load;

    // Input synchronizer, preset to mark so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= '1;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_p0[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (mclkx16) begin
            case (state)
                IDLE:    if (!rxs) state_nx = START;
                START:   if (cnt == 4'd7) state_nx = rxs ? IDLE : DATA;
                DATA:    if (cnt == 4'd15 && bitn == 3'd7) state_nx = STOP;
                STOP:    if (cnt == 4'd15) state_nx = rxs ? IDLE : BRK;
                BRK:     if (rxs) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        load = mclkx16 && (state == STOP) && (cnt == 4'd15);
    end

    // Tick counter and bit index; cnt wraps naturally so each sample lands mid-bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= 4'd0;
            bitn <= 3'd0;
        end else if (mclkx16) begin
            case (state)
                START: begin
                    if (cnt == 4'd7) begin
                        cnt  <= 4'd0;
                        bitn <= 3'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DATA: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) bitn <= bitn + 3'd1;
                end
                STOP:    cnt <= cnt + 4'd1;
                default: cnt <= 4'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mclkx16 && state == DATA && cnt == 4'd15) begin
            shift <= {rxs, shift[7:1]};
        end
    end

    // Holding register: a load in the same clock as a read wins, but still counts as consumed
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_rdy       <= 1'b0;
            rx_data      <= 8'h00;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else if (load) begin
            rx_data      <= shift;
            rx_rdy       <= 1'b1;
            rx_frame_err <= ~rxs;
            if (rx_read) begin
                rx_overrun <= 1'b0;
            end else if (rx_rdy) begin
                rx_overrun <= 1'b1;
            end
        end else if (rx_read) begin
            rx_rdy       <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of plain frames plus hand-written overrun, break,
// read-on-load and mid-frame reset sequences, checked through a scoreboard queue.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       mclkx16;
    logic       rx;
    logic       rx_read;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       ov;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    logic [1:0] divc = 2'd0;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .mclkx16     (mclkx16),
        .rx          (rx),
        .rx_read     (rx_read),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every 4 clk, changed on the falling edge so it is stable at posedge
    initial mclkx16 = 1'b0;
    always @(negedge clk) begin
        divc = divc + 2'd1;
        mclkx16 = (divc == 2'd0);
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic lvl, input int nclk);
        rx = lvl;
        repeat (nclk) @(negedge clk);
    endtask

    // Leaves rx at the stop-bit level; the caller decides what follows
    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge clk);
        drive_bit(1'b0, 64);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 64);
        drive_bit(stop, 64);
    endtask

    task automatic idle(input int nclk);
        drive_bit(1'b1, nclk);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic fe, input logic ov);
        exp_t e;
        e.data = d;
        e.fe   = fe;
        e.ov   = ov;
        sb.push_back(e);
    endtask

    task automatic check_load(input string name);
        exp_t e;
        int n = 0;
        while (!rx_rdy && n < 800) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_sb: got empty required entry", name);
            return;
        end
        e = sb.pop_front();
        chk({name, "_rdy"}, {31'd0, rx_rdy}, 32'd1);
        chk({name, "_data"}, {24'd0, rx_data}, {24'd0, e.data});
        chk({name, "_fe"}, {31'd0, rx_frame_err}, {31'd0, e.fe});
        chk({name, "_ov"}, {31'd0, rx_overrun}, {31'd0, e.ov});
    endtask

    // Start edge reaches rxs after two clocks; the first tick after that is tick 0,
    // and the byte loads on tick 152. Raise rx_read for exactly that clock.
    task automatic read_at_load();
        int n;
        @(negedge clk);
        repeat (2) @(posedge clk);
        do @(posedge clk); while (!mclkx16);
        n = 0;
        while (n < 151) begin
            @(posedge clk);
            if (mclkx16) n++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    initial begin
        vecs[0] = '{data: 8'h55, stop: 1'b1, exp_data: 8'h55, exp_fe: 1'b0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_fe: 1'b0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_fe: 1'b0};
        vecs[3] = '{data: 8'h80, stop: 1'b1, exp_data: 8'h80, exp_fe: 1'b0};
        vecs[4] = '{data: 8'h3C, stop: 1'b0, exp_data: 8'h3C, exp_fe: 1'b1};
        vecs[5] = '{data: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_fe: 1'b0};

        rst     = 1'b0;
        rx      = 1'b1;
        rx_read = 1'b0;
        repeat (6) @(negedge clk);
        chk("reset_rdy", {31'd0, rx_rdy}, 32'd0);
        chk("reset_data", {24'd0, rx_data}, 32'd0);
        chk("reset_fe", {31'd0, rx_frame_err}, 32'd0);
        chk("reset_ov", {31'd0, rx_overrun}, 32'd0);
        rst = 1'b1;
        idle(64);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            push_exp(vecs[i].exp_data, vecs[i].exp_fe, 1'b0);
            check_load($sformatf("vec%0d", i));
            pulse_read();
            chk($sformatf("vec%0d_read_rdy", i), {31'd0, rx_rdy}, 32'd0);
            chk($sformatf("vec%0d_read_fe", i), {31'd0, rx_frame_err}, 32'd0);
            chk($sformatf("vec%0d_hold", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
            idle(128);
        end

        // Short low glitch must be rejected at start validation
        @(negedge clk);
        drive_bit(1'b0, 20);
        idle(800);
        chk("glitch_rdy", {31'd0, rx_rdy}, 32'd0);
        chk("glitch_data", {24'd0, rx_data}, 32'hA5);

        // Overrun: two bytes without a read
        send_frame(8'hA3, 1'b1);
        push_exp(8'hA3, 1'b0, 1'b0);
        check_load("ovr_first");
        idle(128);
        send_frame(8'h0F, 1'b1);
        push_exp(8'h0F, 1'b0, 1'b1);
        check_load("ovr_second");
        pulse_read();
        chk("ovr_read_rdy", {31'd0, rx_rdy}, 32'd0);
        chk("ovr_read_ov", {31'd0, rx_overrun}, 32'd0);
        chk("ovr_read_fe", {31'd0, rx_frame_err}, 32'd0);
        idle(128);

        // Framing error followed by a held break
        send_frame(8'hC3, 1'b0);
        push_exp(8'hC3, 1'b1, 1'b0);
        check_load("brk_byte");
        pulse_read();
        drive_bit(1'b0, 160);
        chk("brk_low_rdy", {31'd0, rx_rdy}, 32'd0);
        chk("brk_low_data", {24'd0, rx_data}, 32'hC3);
        idle(128);
        send_frame(8'h7E, 1'b1);
        push_exp(8'h7E, 1'b0, 1'b0);
        check_load("brk_next");
        idle(64);

        // Read strobe lands on the load clock of 0x81 while 0x7E is still held
        fork
            send_frame(8'h81, 1'b1);
            read_at_load();
        join
        push_exp(8'h81, 1'b0, 1'b0);
        check_load("rdload");
        pulse_read();
        chk("rdload_after_rdy", {31'd0, rx_rdy}, 32'd0);
        idle(128);

        // Reset in the middle of a frame aborts it
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (300) @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                rst = 1'b1;
            end
        join
        idle(200);
        chk("rstmid_rdy", {31'd0, rx_rdy}, 32'd0);
        chk("rstmid_data", {24'd0, rx_data}, 32'd0);
        send_frame(8'h12, 1'b1);
        push_exp(8'h12, 1'b0, 1'b0);
        check_load("rstmid_next");
        idle(64);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
